// File: rtl/pipe_trace_pkg.sv
// Shared types and constants for the pipeline trace generator.
// Record field widths follow ID_W_DEF / CYC_W_DEF; the module parameters
// ID_W / CYC_W size the internal counters and are meant to match them.
package pipe_trace_pkg;

  localparam int ID_W_DEF  = 7;
  localparam int CYC_W_DEF = 16;
  localparam int DEPTH_DEF = 4;
  localparam int NUM_STG   = 5;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  typedef struct packed {
    logic [NUM_STG-1:0]               stage_vld;
    logic [NUM_STG-1:0][ID_W_DEF-1:0] stage_id;
    logic                             stall;
    logic                             flush;
    logic                             kill_vld;
    logic [ID_W_DEF-1:0]              kill_id;
    logic [CYC_W_DEF-1:0]             cycle;
  } trace_rec_t;

endpackage

// File: rtl/pipe_trace_if.sv
// Trace event stream: valid/ready handshake carrying one trace record.
interface pipe_trace_if;
  import pipe_trace_pkg::*;

  logic       ev_valid;
  logic       ev_ready;
  trace_rec_t ev_rec;

  modport master (output ev_valid, output ev_rec, input ev_ready);
  modport slave  (input ev_valid, input ev_rec, output ev_ready);
endinterface

// File: rtl/pipe_trace_gen_fifo.sv
// trace_fifo: registered-output-free record queue, no fall-through.
// A push into a full queue is accepted only when a pop frees a slot
// in the same cycle.
module trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset discards every queued record.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/pipe_trace_gen.sv
// pipe_trace_gen: models a 5-stage pipeline (IF,ID,EX,MEM,WB) and emits one
// trace record per active cycle into a small queue drained over ev.
// Optional macro PIPE_TRACE_KILL_EN adds kill reporting for flushed fetches;
// without it kill_vld/kill_id stay 0.
// IDs of invalid stages are reported as 0 so records compare cleanly.
module pipe_trace_gen
  import pipe_trace_pkg::*;
#(
  parameter int ID_W  = ID_W_DEF,
  parameter int CYC_W = CYC_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  pipe_trace_if.master ev,
  output logic         overflow,
  output logic [7:0]   drop_cnt
);
  localparam int REC_W = $bits(trace_rec_t);

  logic [NUM_STG-1:0]           vld_q;
  logic [NUM_STG-1:0][ID_W-1:0] id_q;
  logic [ID_W-1:0]              next_id_q;
  logic [CYC_W-1:0]             cyc_q;
  trace_rec_t                   rec;
  logic                         push;
  logic                         pop;
  logic                         full;
  logic                         empty;
  logic                         drop;
  logic [REC_W-1:0]             fifo_dout;

  // Stage state and cycle stamp; stall holds IF/ID and bubbles EX,
  // flush bubbles ID while the old ID contents move on to EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= '0;
      id_q      <= '0;
      next_id_q <= '0;
      cyc_q     <= '0;
    end else begin
      cyc_q          <= cyc_q + CYC_W'(1);
      vld_q[STG_WB]  <= vld_q[STG_MEM];
      id_q[STG_WB]   <= id_q[STG_MEM];
      vld_q[STG_MEM] <= vld_q[STG_EX];
      id_q[STG_MEM]  <= id_q[STG_EX];
      if (stall) begin
        vld_q[STG_EX] <= 1'b0;
      end else begin
        vld_q[STG_EX] <= vld_q[STG_ID];
        id_q[STG_EX]  <= id_q[STG_ID];
        vld_q[STG_ID] <= vld_q[STG_IF] & ~flush;
        id_q[STG_ID]  <= id_q[STG_IF];
        vld_q[STG_IF] <= 1'b1;
        id_q[STG_IF]  <= next_id_q;
        next_id_q     <= next_id_q + ID_W'(1);
      end
    end
  end

  // Assemble this cycle's record from the pre-edge stage state.
  always_comb begin
    rec       = '0;
    rec.stall = stall;
    rec.flush = flush;
    rec.cycle = CYC_W_DEF'(cyc_q);
    for (int s = 0; s < NUM_STG; s++) begin
      rec.stage_vld[s] = vld_q[s];
      rec.stage_id[s]  = vld_q[s] ? ID_W_DEF'(id_q[s]) : '0;
    end
`ifdef PIPE_TRACE_KILL_EN
    if (flush && !stall) begin
      rec.kill_vld = 1'b1;
      rec.kill_id  = rec.stage_id[STG_IF];
    end
`endif
  end

  assign push        = (|vld_q) | stall | flush;
  assign pop         = ev.ev_valid & ev.ev_ready;
  assign drop        = push & full & ~pop;
  assign ev.ev_valid = ~empty;
  assign ev.ev_rec   = trace_rec_t'(fifo_dout);

  trace_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (rec),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  // Sticky overflow and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_pipe_trace_gen.sv
// Bench for pipe_trace_gen: directed scenarios plus random stall/flush/ready
// traffic, all checked against a queue-based reference model.
module tb_pipe_trace_gen;
  import pipe_trace_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic       flush;
  logic       overflow;
  logic [7:0] drop_cnt;

  pipe_trace_if ev ();

  pipe_trace_gen #(.ID_W(ID_W_DEF), .CYC_W(CYC_W_DEF), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .flush    (flush),
    .ev       (ev),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: stage contents as IDs (-1 = empty), plus record queue.
  int         m_stg [NUM_STG];
  int         m_nid;
  int         m_cyc;
  trace_rec_t m_q [$];
  bit         m_ovf;
  int         m_drops;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic trace_rec_t mk_rec(bit st, bit fl);
    trace_rec_t r;
    r       = '0;
    r.stall = st;
    r.flush = fl;
    r.cycle = CYC_W_DEF'(m_cyc);
    for (int s = 0; s < NUM_STG; s++) begin
      if (m_stg[s] >= 0) begin
        r.stage_vld[s] = 1'b1;
        r.stage_id[s]  = ID_W_DEF'(m_stg[s]);
      end
    end
`ifdef PIPE_TRACE_KILL_EN
    if (fl && !st) begin
      r.kill_vld = 1'b1;
      r.kill_id  = (m_stg[0] >= 0) ? ID_W_DEF'(m_stg[0]) : '0;
    end
`endif
    return r;
  endfunction

  task automatic model_advance(bit st, bit fl, bit rdy, bit r);
    trace_rec_t rec;
    bit         gen;
    int         nxt [NUM_STG];
    if (r) begin
      for (int s = 0; s < NUM_STG; s++) m_stg[s] = -1;
      m_nid   = 0;
      m_cyc   = 0;
      m_q.delete();
      m_ovf   = 0;
      m_drops = 0;
      return;
    end
    gen = st || fl;
    for (int s = 0; s < NUM_STG; s++) if (m_stg[s] >= 0) gen = 1;
    rec = mk_rec(st, fl);
    if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
    if (gen) begin
      if (m_q.size() < DEPTH) m_q.push_back(rec);
      else begin
        m_ovf = 1;
        if (m_drops < 255) m_drops++;
      end
    end
    nxt    = m_stg;
    nxt[4] = m_stg[3];
    nxt[3] = m_stg[2];
    if (st) nxt[2] = -1;
    else begin
      nxt[2] = m_stg[1];
      nxt[1] = fl ? -1 : m_stg[0];
      nxt[0] = m_nid;
      m_nid  = (m_nid + 1) % (1 << ID_W_DEF);
    end
    m_stg = nxt;
    m_cyc = (m_cyc + 1) % (1 << CYC_W_DEF);
  endtask

  task automatic check_outputs();
    chk("ev_valid", 128'(ev.ev_valid), 128'(m_q.size() > 0));
    if (m_q.size() > 0) chk("ev_rec", 128'(ev.ev_rec), 128'(m_q[0]));
    chk("overflow", 128'(overflow), 128'(m_ovf));
    chk("drop_cnt", 128'(drop_cnt), 128'(m_drops));
  endtask

  task automatic apply(bit st, bit fl, bit rdy, bit r);
    stall       = st;
    flush       = fl;
    ev.ev_ready = rdy;
    rst         = r;
    model_advance(st, fl, rdy, r);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(bit st, bit fl, bit rdy, bit r);
    check_outputs();
    apply(st, fl, rdy, r);
  endtask

  initial begin
    apply(0, 0, 1, 1);

    // Free-running fill: record of cycle 5 is at the head in cycle 6.
    for (int k = 0; k < 6; k++) step(0, 0, 1, 0);
    chk("fill_vld", 128'(ev.ev_rec.stage_vld), 128'(5'b11111));
    chk("fill_if",  128'(ev.ev_rec.stage_id[STG_IF]),  128'(4));
    chk("fill_id",  128'(ev.ev_rec.stage_id[STG_ID]),  128'(3));
    chk("fill_ex",  128'(ev.ev_rec.stage_id[STG_EX]),  128'(2));
    chk("fill_mem", 128'(ev.ev_rec.stage_id[STG_MEM]), 128'(1));
    chk("fill_wb",  128'(ev.ev_rec.stage_id[STG_WB]),  128'(0));
    chk("fill_cyc", 128'(ev.ev_rec.cycle), 128'(5));

    // Two-cycle stall with IF=5, ID=4.
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    chk("stall_ex0", 128'(ev.ev_rec.stage_vld[STG_EX]), 128'(0));
    chk("stall_if",  128'(ev.ev_rec.stage_id[STG_IF]), 128'(5));
    chk("stall_id",  128'(ev.ev_rec.stage_id[STG_ID]), 128'(4));
    step(0, 0, 1, 0);
    chk("stall_ex1", 128'(ev.ev_rec.stage_vld[STG_EX]), 128'(0));
    step(0, 0, 1, 0);
    chk("post_stall_if", 128'(ev.ev_rec.stage_id[STG_IF]), 128'(6));

    // Flush with IF=7, ID=6.
    step(0, 1, 1, 0);
    chk("flush_bit", 128'(ev.ev_rec.flush), 128'(1));
    chk("flush_if",  128'(ev.ev_rec.stage_id[STG_IF]), 128'(7));
`ifdef PIPE_TRACE_KILL_EN
    chk("kill_vld", 128'(ev.ev_rec.kill_vld), 128'(1));
    chk("kill_id",  128'(ev.ev_rec.kill_id), 128'(7));
`else
    chk("kill_vld", 128'(ev.ev_rec.kill_vld), 128'(0));
    chk("kill_id",  128'(ev.ev_rec.kill_id), 128'(0));
`endif
    step(0, 0, 1, 0);
    chk("flush_id_vld", 128'(ev.ev_rec.stage_vld[STG_ID]), 128'(0));
    chk("flush_ex",     128'(ev.ev_rec.stage_id[STG_EX]), 128'(6));

    // Queue three records, then reset.
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("rst_valid", 128'(ev.ev_valid), 128'(0));

    // Consumer stalled: 7 records offered to a 4-deep queue.
    for (int k = 0; k < 8; k++) step(0, 0, 0, 0);
    chk("ovf_drops", 128'(drop_cnt), 128'(3));
    chk("ovf_flag",  128'(overflow), 128'(1));
    chk("ovf_head_cyc", 128'(ev.ev_rec.cycle), 128'(1));
    chk("ovf_head_if",  128'(ev.ev_rec.stage_id[STG_IF]), 128'(0));
    chk("ovf_head_vld", 128'(ev.ev_rec.stage_vld), 128'(5'b00001));

    // Full queue with simultaneous pop and push.
    step(0, 0, 1, 0);
    chk("full_pop_drops", 128'(drop_cnt), 128'(3));
    chk("full_pop_head",  128'(ev.ev_rec.cycle), 128'(2));
    step(0, 0, 0, 0);
    chk("still_full_drops", 128'(drop_cnt), 128'(4));

    // Random traffic.
    for (int k = 0; k < 500; k++) begin
      step($urandom_range(3) == 0, $urandom_range(4) == 0,
           $urandom_range(9) < 6, $urandom_range(199) == 0);
    end

    // Long consumer stall: drop counter saturates.
    step(0, 0, 0, 1);
    for (int k = 0; k < 300; k++) step(0, 0, 0, 0);
    chk("drop_sat", 128'(drop_cnt), 128'(255));
    for (int k = 0; k < 8; k++) step($urandom_range(3) == 0, 0, 1, 0);
    check_outputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
